// File: rtl/rr_arb_mux_4_1.sv
// rr_arb_mux_4_1: round-robin arbiter in front of a 4:1 word mux with one
// registered output stage.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid[3:0]         per-channel valid
//   in_data0..in_data3    per-channel words (W bits)
//   in_ready[3:0]         per-channel ready, one-hot or zero (combinational)
//   out_valid             output register holds a word
//   out_data              registered selected word
//   out_sel               registered index of the source channel
//   out_ready             consumer accepts out_data this cycle
module rr_arb_mux_4_1 #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [W-1:0] in_data0,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] in_data3,
  output logic [3:0]   in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel,
  input  logic         out_ready
);

  localparam int unsigned NCH = 4;
  localparam int unsigned SW  = 2;

  logic [SW-1:0] last;
  logic [SW-1:0] grant;
  logic [W-1:0]  grant_data;
  logic          any_valid;
  logic          load;

  // The output register can take a word when empty or being drained.
  assign load      = !out_valid || out_ready;
  assign any_valid = |in_valid;

  // Round-robin search starting just after the last grant; last is lowest priority.
  // The 2-bit index wraps 3+1 to 0 on its own.
  always_comb begin
    logic          found;
    logic [SW-1:0] idx;
    grant = last;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= int'(NCH); k++) begin
      idx = last + SW'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // 4:1 word mux indexed by the grant.
  always_comb begin
    grant_data = '0;
    case (grant)
      2'd0:    grant_data = in_data0;
      2'd1:    grant_data = in_data1;
      2'd2:    grant_data = in_data2;
      default: grant_data = in_data3;
    endcase
  end

  // Handshake only toward the granted channel, and only when a capture will happen.
  always_comb begin
    in_ready = '0;
    if (load && any_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output register and arbitration pointer; nothing moves on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SW'(NCH - 1);
    end else if (load) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        last      <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed bench for rr_arb_mux_4_1: rotation, single requester, backpressure,
// pointer wrap, mid-run reset and idle drain, each with hand-computed expectations.
module tb_rr_arb_mux_4_1;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;

  rr_arb_mux_4_1 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                         input logic [W-1:0] d);
    chk({tag, "_valid"}, 8'(out_valid), 8'(v));
    chk({tag, "_sel"},   8'(out_sel),   8'(s));
    chk({tag, "_data"},  8'(out_data),  8'(d));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    in_data0  = 4'd1;
    in_data1  = 4'd2;
    in_data2  = 4'd3;
    in_data3  = 4'd4;

    // Reset state
    tick();
    chk_out("rst", 1'b0, 2'd0, 4'd0);
    rst = 1'b0;

    // 1: all valid, rotation starting at channel 0
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t1_rdy%0d", i), 8'(in_ready), 8'(4'b0001 << (i % 4)));
      tick();
      chk_out($sformatf("t1_out%0d", i), 1'b1, 2'(i % 4), 4'((i % 4) + 1));
    end
    // last = 1

    // 2: only channel 2 requests, captured every cycle
    in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t2_rdy%0d", i), 8'(in_ready), 8'(4'b0100));
      tick();
      chk_out($sformatf("t2_out%0d", i), 1'b1, 2'd2, 4'd3);
    end

    // 3: hold sel=1 under backpressure, then release
    in_valid = 4'b0010;
    tick();
    chk_out("t3_load", 1'b1, 2'd1, 4'd2);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t3_stall_rdy%0d", i), 8'(in_ready), 8'(4'b0000));
      tick();
      chk_out($sformatf("t3_stall%0d", i), 1'b1, 2'd1, 4'd2);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_rel_rdy", 8'(in_ready), 8'(4'b0100));
    tick();
    chk_out("t3_rel", 1'b1, 2'd2, 4'd3);

    // 4: last=1 with requests on 0 and 3 -> 3 then wrap to 0
    in_valid = 4'b0010;
    tick();
    chk_out("t4_set", 1'b1, 2'd1, 4'd2);
    in_valid = 4'b1001;
    #1;
    chk("t4_rdy_a", 8'(in_ready), 8'(4'b1000));
    tick();
    chk_out("t4_a", 1'b1, 2'd3, 4'd4);
    #1;
    chk("t4_rdy_b", 8'(in_ready), 8'(4'b0001));
    tick();
    chk_out("t4_b", 1'b1, 2'd0, 4'd1);

    // 5: reset while holding a word from channel 2
    in_valid = 4'b0100;
    tick();
    chk_out("t5_set", 1'b1, 2'd2, 4'd3);
    in_valid = 4'b1111;
    rst      = 1'b1;
    tick();
    chk_out("t5_rst", 1'b0, 2'd0, 4'd0);
    rst = 1'b0;
    #1;
    chk("t5_rdy", 8'(in_ready), 8'(4'b0001));
    tick();
    chk_out("t5_first", 1'b1, 2'd0, 4'd1);

    // 6: no requests -> register drains, data/sel hold, pointer holds
    in_valid = 4'b0000;
    #1;
    chk("t6_rdy", 8'(in_ready), 8'(4'b0000));
    tick();
    chk_out("t6_drain", 1'b0, 2'd0, 4'd1);
    tick();
    chk_out("t6_idle", 1'b0, 2'd0, 4'd1);
    in_valid = 4'b1111;
    #1;
    chk("t6_resume_rdy", 8'(in_ready), 8'(4'b0010));
    tick();
    chk_out("t6_resume", 1'b1, 2'd1, 4'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
